lsu: RTL
========

Name: lsu

Overview:
Load/store unit for the MEM stage.
- Accepts a memory op plus the effective address computed by the EX-stage ALU.
- Issues it on the SRAM-like data bus (req/addr_ok, then data_ok).
- Aligns and extends load data; checks alignment and raises AdEL/AdES.
- Hands one result per accepted op to WB via a valid/ready handshake.

Parameters:
ADDR_WIDTH, 32, width of the effective and bus addresses.

Ports:
clk  in  1  clock; all state on its rising edge
resetn  in  1  asynchronous active-low reset
in_valid  in  1  EX presents an op
in_ready  out  1  unit can accept (state IDLE)
in_op  in  8  one-hot: LB, LBU, LH, LHU, LW, SB, SH, SW (bit indices in lsu.vh)
in_addr  in  ADDR_WIDTH  effective byte address (ALU address output)
in_wdata  in  32  store data (rt), low bits significant for SB/SH
flush  in  1  kill the in-flight op (exception/eret in a later stage)
data_req  out  1  bus request
data_wr  out  1  1 = store
data_size  out  2  0 = byte, 1 = half, 2 = word
data_addr  out  ADDR_WIDTH  byte address, unmodified
data_wstrb  out  4  byte enables (stores), 0 for loads
data_wdata  out  32  lane-replicated store data
data_addr_ok  in  1  request accepted this cycle
data_data_ok  in  1  response/read data valid this cycle
data_rdata  in  32  read word
out_valid  out  1  result held for WB
out_ready  in  1  WB consumes
out_rdata  out  32  aligned, extended load result (0 for stores)
out_exc  out  1  address error
out_exc_code  out  5  5'h04 AdEL, 5'h05 AdES
out_badvaddr  out  ADDR_WIDTH  faulting address

Behaviour:
Reset (resetn low, asynchronous):
- State IDLE, cancel flag 0.
- data_req = 0, out_valid = 0, out_exc = 0, out_rdata = 0.
- in_ready = 1 (derived from state).

States:
- IDLE: in_ready = 1. An op is accepted on in_valid & in_ready; op, addr and wdata are registered.
  - Misaligned (halfword with addr[0] = 1; word with addr[1:0] != 0): no bus request. Go to DONE with out_exc = 1, code AdEL (loads) or AdES (stores), out_badvaddr = addr.
  - Aligned: go to REQ.
- REQ: data_req = 1. wr, size, addr, wstrb and wdata are held stable until data_addr_ok; then go to WAIT. The request is never withdrawn.
- WAIT: on data_data_ok, latch out_rdata from data_rdata via load_align, go to DONE. data_data_ok never arrives in the same cycle as its data_addr_ok (bus guarantee); data_data_ok in IDLE/REQ/DONE is ignored.
- DONE: out_valid = 1, outputs stable. On out_ready, go to IDLE. The next op is accepted no earlier than the following cycle, so minimum occupancy is 4 cycles per aligned op.

Store lanes:
- SB: wdata = {4{b[7:0]}}, wstrb = 4'b0001 << addr[1:0].
- SH: wdata = {2{b[15:0]}}, wstrb = addr[1] ? 4'b1100 : 4'b0011.
- SW: wdata = b, wstrb = 4'b1111.

Load lanes:
- LB/LBU: byte at data_rdata[8*addr[1:0] +: 8], sign-/zero-extended.
- LH/LHU: halfword at addr[1], extended.
- LW: whole word.

flush (synchronous, highest priority):
- IDLE: no accept that cycle.
- DONE: go to IDLE, out_valid drops next cycle.
- REQ/WAIT: set cancel. The transaction completes on the bus (a store in REQ is still committed). On its data_data_ok, go to IDLE with no out_valid. Cancel clears on that return.
- flush together with data_data_ok in WAIT: the response is discarded, go to IDLE.

resetn asserted mid-transaction:
- Returns to IDLE immediately. Outstanding bus responses are the bus's responsibility; the unit assumes the bus is also reset.

Decomposition:
- lsu.vh: `define bit indices LSU_LB..LSU_SW, size codes, EXC_ADEL/EXC_ADES.
- Sub-module load_align: combinational; inputs op, addr[1:0], rdata; output 32-bit extended result. Reused by the verification model.

Test Plan:
- LW @0x1000_0004, addr_ok after 2 cycles, data_ok 1 cycle later with 0xDEADBEEF -> data_size = 2, wstrb = 0, out_valid with out_rdata = 0xDEADBEEF, out_exc = 0.
- LB @0x...03, rdata 0x80FF_0000 -> out_rdata 0xFFFF_FF80; LBU same -> 0x0000_0080; LH @0x...02 -> 0xFFFF_80FF.
- SB @0x...02, wdata 0x1234_56AB -> data_wdata 0xABAB_ABAB, wstrb 4'b0100, data_wr = 1; SH @0x...02 -> wdata 0x56AB_56AB, wstrb 4'b1100.
- LW @0x...02 -> no data_req ever, out_exc = 1, code 5'h04, badvaddr = 0x...02; SH @0x...01 -> code 5'h05.
- Flush in WAIT, then data_data_ok -> out_valid stays 0, in_ready = 1 next cycle. Flush in REQ on SW -> request still held until addr_ok, completes, no out_valid.
- out_ready held low 5 cycles in DONE -> out_rdata and out_valid stable, in_ready = 0, new in_valid not accepted. resetn pulse in WAIT -> data_req = 0 and out_valid = 0 immediately.

Source files
------------

// File: rtl/lsu_pkg.sv
// Shared constants and lane helpers for the MEM-stage load/store unit.
package lsu_pkg;

    localparam int LSU_LB  = 0;
    localparam int LSU_LBU = 1;
    localparam int LSU_LH  = 2;
    localparam int LSU_LHU = 3;
    localparam int LSU_LW  = 4;
    localparam int LSU_SB  = 5;
    localparam int LSU_SH  = 6;
    localparam int LSU_SW  = 7;

    localparam logic [1:0] SIZE_BYTE = 2'd0;
    localparam logic [1:0] SIZE_HALF = 2'd1;
    localparam logic [1:0] SIZE_WORD = 2'd2;

    localparam logic [4:0] EXC_ADEL = 5'h04;
    localparam logic [4:0] EXC_ADES = 5'h05;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_WAIT = 2'd2,
        ST_DONE = 2'd3
    } lsu_state_e;

    function automatic logic is_store(input logic [7:0] op);
        return op[LSU_SB] | op[LSU_SH] | op[LSU_SW];
    endfunction

    function automatic logic is_word(input logic [7:0] op);
        return op[LSU_LW] | op[LSU_SW];
    endfunction

    function automatic logic is_half(input logic [7:0] op);
        return op[LSU_LH] | op[LSU_LHU] | op[LSU_SH];
    endfunction

    function automatic logic is_misaligned(input logic [7:0] op, input logic [1:0] a);
        if (is_word(op)) begin
            return (a != 2'b00);
        end else if (is_half(op)) begin
            return a[0];
        end else begin
            return 1'b0;
        end
    endfunction

    function automatic logic [1:0] op_size(input logic [7:0] op);
        if (is_word(op)) begin
            return SIZE_WORD;
        end else if (is_half(op)) begin
            return SIZE_HALF;
        end else begin
            return SIZE_BYTE;
        end
    endfunction

    function automatic logic [3:0] store_wstrb(input logic [7:0] op, input logic [1:0] a);
        if (op[LSU_SW]) begin
            return 4'b1111;
        end else if (op[LSU_SH]) begin
            return a[1] ? 4'b1100 : 4'b0011;
        end else if (op[LSU_SB]) begin
            return 4'b0001 << a;
        end else begin
            return 4'b0000;
        end
    endfunction

    function automatic logic [31:0] store_wdata(input logic [7:0] op, input logic [31:0] b);
        if (op[LSU_SB]) begin
            return {4{b[7:0]}};
        end else if (op[LSU_SH]) begin
            return {2{b[15:0]}};
        end else begin
            return b;
        end
    endfunction

endpackage

// File: rtl/lsu_load_align.sv
// Selects the addressed byte/halfword of a read word and sign- or zero-extends it.
module load_align
    import lsu_pkg::*;
(
    input  logic [7:0]  op,
    input  logic [1:0]  addr,
    input  logic [31:0] rdata,
    output logic [31:0] result
);

    logic [7:0]  byte_s;
    logic [15:0] half_s;

    // Lane select and extension; stores produce zero.
    always_comb begin
        byte_s = 8'h00;
        half_s = addr[1] ? rdata[31:16] : rdata[15:0];
        case (addr)
            2'd0:    byte_s = rdata[7:0];
            2'd1:    byte_s = rdata[15:8];
            2'd2:    byte_s = rdata[23:16];
            2'd3:    byte_s = rdata[31:24];
            default: byte_s = 8'h00;
        endcase
        result = 32'h0000_0000;
        if (op[LSU_SB] | op[LSU_SH] | op[LSU_SW]) begin
            result = 32'h0000_0000;
        end else if (op[LSU_LB]) begin
            result = {{24{byte_s[7]}}, byte_s};
        end else if (op[LSU_LBU]) begin
            result = {24'h00_0000, byte_s};
        end else if (op[LSU_LH]) begin
            result = {{16{half_s[15]}}, half_s};
        end else if (op[LSU_LHU]) begin
            result = {16'h0000, half_s};
        end else if (op[LSU_LW]) begin
            result = rdata;
        end else begin
            result = 32'h0000_0000;
        end
    end

endmodule

// File: rtl/lsu.sv
// MEM-stage load/store unit: one op at a time over an SRAM-like req/addr_ok/data_ok bus.
module lsu
    import lsu_pkg::*;
#(
    parameter int ADDR_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  resetn,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [7:0]            in_op,
    input  logic [ADDR_WIDTH-1:0] in_addr,
    input  logic [31:0]           in_wdata,
    input  logic                  flush,
    output logic                  data_req,
    output logic                  data_wr,
    output logic [1:0]            data_size,
    output logic [ADDR_WIDTH-1:0] data_addr,
    output logic [3:0]            data_wstrb,
    output logic [31:0]           data_wdata,
    input  logic                  data_addr_ok,
    input  logic                  data_data_ok,
    input  logic [31:0]           data_rdata,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [31:0]           out_rdata,
    output logic                  out_exc,
    output logic [4:0]            out_exc_code,
    output logic [ADDR_WIDTH-1:0] out_badvaddr
);

    lsu_state_e            state_r;
    logic                  cancel_r;
    logic [7:0]            op_r;
    logic [ADDR_WIDTH-1:0] addr_r;
    logic                  wr_r;
    logic [1:0]            size_r;
    logic [3:0]            wstrb_r;
    logic [31:0]           wdata_r;
    logic                  data_req_r;
    logic                  out_valid_r;
    logic [31:0]           out_rdata_r;
    logic                  out_exc_r;
    logic [4:0]            out_exc_code_r;
    logic [ADDR_WIDTH-1:0] out_badvaddr_r;
    logic [31:0]           align_s;

    load_align u_align (
        .op     (op_r),
        .addr   (addr_r[1:0]),
        .rdata  (data_rdata),
        .result (align_s)
    );

    // Control FSM; bus request fields are captured once at accept and held until addr_ok.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_r        <= ST_IDLE;
            cancel_r       <= 1'b0;
            op_r           <= 8'h00;
            addr_r         <= '0;
            wr_r           <= 1'b0;
            size_r         <= SIZE_BYTE;
            wstrb_r        <= 4'b0000;
            wdata_r        <= 32'h0000_0000;
            data_req_r     <= 1'b0;
            out_valid_r    <= 1'b0;
            out_rdata_r    <= 32'h0000_0000;
            out_exc_r      <= 1'b0;
            out_exc_code_r <= 5'h00;
            out_badvaddr_r <= '0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (!flush && in_valid) begin
                        op_r           <= in_op;
                        addr_r         <= in_addr;
                        wr_r           <= is_store(in_op);
                        size_r         <= op_size(in_op);
                        wstrb_r        <= store_wstrb(in_op, in_addr[1:0]);
                        wdata_r        <= store_wdata(in_op, in_wdata);
                        out_rdata_r    <= 32'h0000_0000;
                        out_badvaddr_r <= in_addr;
                        if (is_misaligned(in_op, in_addr[1:0])) begin
                            state_r        <= ST_DONE;
                            out_valid_r    <= 1'b1;
                            out_exc_r      <= 1'b1;
                            out_exc_code_r <= is_store(in_op) ? EXC_ADES : EXC_ADEL;
                        end else begin
                            state_r        <= ST_REQ;
                            data_req_r     <= 1'b1;
                            out_exc_r      <= 1'b0;
                            out_exc_code_r <= 5'h00;
                        end
                    end
                end
                ST_REQ: begin
                    if (flush) begin
                        cancel_r <= 1'b1;
                    end
                    if (data_addr_ok) begin
                        data_req_r <= 1'b0;
                        state_r    <= ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    if (data_data_ok) begin
                        cancel_r <= 1'b0;
                        if (flush || cancel_r) begin
                            state_r <= ST_IDLE;
                        end else begin
                            state_r     <= ST_DONE;
                            out_valid_r <= 1'b1;
                            out_rdata_r <= wr_r ? 32'h0000_0000 : align_s;
                        end
                    end else if (flush) begin
                        cancel_r <= 1'b1;
                    end
                end
                ST_DONE: begin
                    if (flush || out_ready) begin
                        state_r     <= ST_IDLE;
                        out_valid_r <= 1'b0;
                        out_exc_r   <= 1'b0;
                    end
                end
                default: begin
                    state_r     <= ST_IDLE;
                    cancel_r    <= 1'b0;
                    data_req_r  <= 1'b0;
                    out_valid_r <= 1'b0;
                    out_exc_r   <= 1'b0;
                end
            endcase
        end
    end

    assign in_ready     = (state_r == ST_IDLE);
    assign data_req     = data_req_r;
    assign data_wr      = wr_r;
    assign data_size    = size_r;
    assign data_addr    = addr_r;
    assign data_wstrb   = wstrb_r;
    assign data_wdata   = wdata_r;
    assign out_valid    = out_valid_r;
    assign out_rdata    = out_rdata_r;
    assign out_exc      = out_exc_r;
    assign out_exc_code = out_exc_code_r;
    assign out_badvaddr = out_badvaddr_r;

endmodule
